// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one outstanding single-beat read or write per local command.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  input  logic [3:0]            i_cmd_wstrb,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic                  o_axi_awvalid,
  input  logic                  i_axi_awready,
  output logic [DATA_WIDTH-1:0] o_axi_wdata,
  output logic [3:0]            o_axi_wstrb,
  output logic                  o_axi_wvalid,
  input  logic                  i_axi_wready,
  input  logic                  i_axi_bvalid,
  input  logic [1:0]            i_axi_bresp,
  output logic                  o_axi_bready,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  input  logic                  i_axi_rvalid,
  input  logic [DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]            i_axi_rresp,
  output logic                  o_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  w_accept;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_waiting;
  logic                  w_timeout;

  // Ready is gated by reset so nothing can be accepted while the block is held.
  assign o_cmd_ready   = (r_state == S_IDLE) && !reset;
  assign o_busy        = (r_state != S_IDLE);
  assign o_rsp_valid   = (r_state == S_DONE);
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_axi_awaddr  = r_addr;
  assign o_axi_araddr  = r_addr;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_awvalid = (r_state == S_WR_REQ) && !r_aw_done;
  assign o_axi_wvalid  = (r_state == S_WR_REQ) && !r_w_done;
  assign o_axi_arvalid = (r_state == S_RD_REQ);
  assign o_axi_bready  = (r_state == S_WR_RESP);
  assign o_axi_rready  = (r_state == S_RD_DATA);

  assign w_accept  = i_cmd_valid && o_cmd_ready;
  assign w_aw_hs   = o_axi_awvalid && i_axi_awready;
  assign w_w_hs    = o_axi_wvalid && i_axi_wready;
  assign w_waiting = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) || (r_state == S_RD_DATA);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // Fires on the cycle whose closing edge would bring the count to the limit.
  assign w_timeout = w_waiting && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = i_cmd_we ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next_state = S_WR_RESP;
      S_WR_RESP: if (i_axi_bvalid) w_next_state = S_DONE;
      S_RD_REQ:  if (i_axi_arready) w_next_state = S_RD_DATA;
      S_RD_DATA: if (i_axi_rvalid) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
    if (w_timeout) w_next_state = S_DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_wstrb   <= i_cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      // AW and W complete independently; each valid drops after its own handshake.
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_timeout) begin
        r_rsp_resp  <= 2'b11;
        r_rsp_rdata <= '0;
      end else if ((r_state == S_WR_RESP) && i_axi_bvalid) begin
        r_rsp_resp <= i_axi_bresp;
      end else if ((r_state == S_RD_DATA) && i_axi_rvalid) begin
        r_rsp_resp  <= i_axi_rresp;
        r_rsp_rdata <= i_axi_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a wait-state-configurable AXI-Lite slave responder.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [31:0] cfg_rdata = '0;
  logic        force_b = 1'b0;

  int          n_chk = 0, n_pass = 0;
  int          rsp_pulses = 0;
  logic        tr_aw [0:255];
  logic        tr_w  [0:255];

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_busy(busy),
    .o_axi_awaddr(awaddr), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bvalid(bvalid), .i_axi_bresp(bresp), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rvalid(rvalid), .i_axi_rdata(rdata), .i_axi_rresp(rresp), .o_axi_rready(rready)
  );

  // Slave responder: each ready/valid rises after its configured number of wait cycles.
  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_wait); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (bready) begin bvalid = (b_cnt >= b_wait); bresp = cfg_bresp; b_cnt++; end
    else begin bvalid = force_b; b_cnt = 0; end
    if (arvalid) begin arready = (ar_cnt >= ar_wait); ar_cnt++; end
    else begin arready = 1'b0; ar_cnt = 0; end
    if (rready) begin rvalid = (r_cnt >= r_wait); rdata = cfg_rdata; rresp = cfg_rresp; r_cnt++; end
    else begin rvalid = 1'b0; r_cnt = 0; end
    if (rsp_valid) rsp_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle 1 is the accept cycle; lat is the cycle number in which rsp_valid is seen.
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 2;
    tr_aw[lat] = awvalid; tr_w[lat] = wvalid;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      tr_aw[lat] = awvalid; tr_w[lat] = wvalid;
    end
    check("rsp_seen", rsp_valid, 1);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    int lat;
    int snap;
    // Reset state
    #1;
    check("rst_outputs", {cmd_ready, busy, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    check("rst_rsp", {rsp_rdata, rsp_resp}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_ready", cmd_ready, 1);

    // Zero-wait write: AW and W together in cycle 2, response in cycle 4
    run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat);
    check("wr_latency", lat, 4);
    check("wr_aw_w_same_cycle", {tr_aw[2], tr_w[2]}, 2'b11);
    check("wr_resp", rsp_resp, 2'b00);
    check("wr_payload", {awaddr, wdata, wstrb}, {32'h0000_0010, 32'hDEAD_BEEF, 4'hF});

    // Read with 3 R wait cycles: RD_REQ c2, RD_DATA c3..c6, DONE c7
    r_wait = 3; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    run_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, lat);
    check("rd_latency", lat, 7);
    check("rd_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_resp", rsp_resp, 2'b00);
    check("rd_araddr", araddr, 32'h0000_0020);
    r_wait = 0;

    // AW completes 2 cycles before W: AW hs c2, W hs c4, B c5, DONE c6
    w_wait = 2;
    run_cmd(1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'h3, lat);
    check("split_aw_first", {tr_aw[2], tr_w[2]}, 2'b11);
    check("split_aw_dropped", {tr_aw[3], tr_w[3]}, 2'b01);
    check("split_w_held", {tr_aw[4], tr_w[4]}, 2'b01);
    check("split_latency", lat, 6);
    w_wait = 0;

    // SLVERR write response; read data stays from the last read
    cfg_bresp = 2'b10;
    run_cmd(1'b1, 32'h0000_0FFC, 32'h0000_00AA, 4'h1, lat);
    check("slverr_latency", lat, 4);
    check("slverr_resp", rsp_resp, 2'b10);
    check("rdata_held", rsp_rdata, 32'h1234_5678);
    cfg_bresp = 2'b00;

    // Stray bvalid while idle is ignored
    force_b = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("stray_b_ignored", {busy, bready, rsp_valid}, 3'b000);
    force_b = 1'b0;

    // Reset asserted in WR_RESP abandons the write
    b_wait = 1000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0080; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !bready; i++) @(negedge clk);
    check("reached_wr_resp", bready, 1);
    snap = rsp_pulses;
    reset = 1'b1;
    #1;
    check("rst_mid_drop", {awvalid, wvalid, arvalid, bready, rready, busy}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    b_wait = 0;
    @(negedge clk);
    check("rst_no_rsp", rsp_pulses, snap);

    // Next command after the abandoned one
    cfg_rdata = 32'hA5A5_0001;
    run_cmd(1'b0, 32'h0000_0024, 32'h0, 4'h0, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_rdata", rsp_rdata, 32'hA5A5_0001);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // arready never rises: accept c1, 16 waiting cycles c2..c17, DONE c18
    ar_wait = 100000;
    run_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0, lat);
    check("tmo_latency", lat, 18);
    check("tmo_resp", rsp_resp, 2'b11);
    check("tmo_rdata", rsp_rdata, 32'h0);
    ar_wait = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
